ram_port_arbiter: RTL

// - Two-master front end for the single-port data/instruction RAM; sits directly upstream of the RAM wrapper.
// - Arbitrates master 0 (instr) and master 1 (data) req/gnt/rvalid ports round-robin onto one RAM port.
// - Returns read data and write completions with fixed 1-cycle latency.
// - Range-checks bus addresses and flags out-of-range accesses.

---
 rtl/ram_arb_pkg.sv | 39 +++
 rtl/ram_port_arbiter_rr.sv | 42 ++++
 rtl/ram_port_arbiter.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/ram_arb_pkg.sv
// ----------------------------------------------------------------------------
// ram_arb_pkg
// Shared types and constants for the two-master RAM port arbiter.
//   master_id_t : identifies master 0 (instr) or master 1 (data)
//   ram_req_t   : one master's request fields {we, be, addr, wdata}
//   ram_resp_t  : registered response tag {vld, id, we, err}
//   sat_inc     : 32-bit saturating increment used by the perf counters
// Handshake (both masters): a request is offered while req=1 and is accepted
// in the cycle gnt=1; exactly RESP_LAT cycles later rvalid=1 for that master.
// There is no response backpressure.
// ----------------------------------------------------------------------------
package ram_arb_pkg;

  localparam int NUM_MASTERS        = 2;
  localparam int RESP_LAT           = 1;
  localparam int DATA_WIDTH_DEF     = 32;
  localparam int BUS_ADDR_WIDTH_DEF = 32;

  typedef logic master_id_t;

  typedef struct packed {
    logic                            we;
    logic [DATA_WIDTH_DEF/8-1:0]     be;
    logic [BUS_ADDR_WIDTH_DEF-1:0]   addr;
    logic [DATA_WIDTH_DEF-1:0]       wdata;
  } ram_req_t;

  typedef struct packed {
    logic       vld;
    master_id_t id;
    logic       we;
    logic       err;
  } ram_resp_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/ram_port_arbiter_rr.sv
// ----------------------------------------------------------------------------
// ram_rr_arbiter
// Two-input round-robin arbiter. Grant is combinational; the pointer rr_q
// names the master that wins a tie and moves to the other master after
// every grant.
//   clk, rst_i : clock, synchronous active-high reset
//   req        : request vector, bit k = master k
//   taken      : a grant was issued this cycle (advances the pointer)
//   gnt        : one-hot grant
//   rr_q       : tie-break pointer (state, exposed for observation)
// ----------------------------------------------------------------------------
module ram_rr_arbiter
  import ram_arb_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_i,
  input  logic [NUM_MASTERS-1:0] req,
  input  logic                   taken,
  output logic [NUM_MASTERS-1:0] gnt,
  output master_id_t             rr_q
);

  always_comb begin
    gnt = '0;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = rr_q ? 2'b10 : 2'b01;
      default: gnt = '0;
    endcase
  end

  // After a grant to master k the pointer favours the other master.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      rr_q <= 1'b0;
    end else if (taken) begin
      rr_q <= ~gnt[1];
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// ----------------------------------------------------------------------------
// ram_port_arbiter
// Front end for the single-port RAM: round-robin between master 0 (instr)
// and master 1 (data), range check of bus addresses, 1-cycle response path.
// Ports:
//   clk, rst_i                    : clock, synchronous active-high reset
//   mN_req_i/addr/we/be/wdata     : master N request (held stable until gnt)
//   mN_gnt_o                      : request accepted this cycle (comb)
//   mN_rvalid_o/rdata_o/err_o     : response, one cycle after the grant
//   ram_en/we/be/addr/wdata_o     : RAM command, all zero when idle
//   ram_rdata_i                   : RAM read data, valid cycle after en
//   perf_clr_i, perf_cnt_o        : perf counters {m1_stall,m1_gnt,m0_stall,m0_gnt}
// Configuration macro: RAM_ARB_PERF_EN enables the saturating perf counters;
// without it perf_cnt_o is 0 and perf_clr_i is ignored.
// ----------------------------------------------------------------------------
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int RAM_SIZE       = 32768,
  parameter int ADDR_WIDTH     = $clog2(RAM_SIZE),
  parameter int DATA_WIDTH     = 32,
  parameter int BUS_ADDR_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst_i,
  input  logic                      m0_req_i,
  output logic                      m0_gnt_o,
  input  logic [BUS_ADDR_WIDTH-1:0] m0_addr_i,
  input  logic                      m0_we_i,
  input  logic [DATA_WIDTH/8-1:0]   m0_be_i,
  input  logic [DATA_WIDTH-1:0]     m0_wdata_i,
  output logic                      m0_rvalid_o,
  output logic [DATA_WIDTH-1:0]     m0_rdata_o,
  output logic                      m0_err_o,
  input  logic                      m1_req_i,
  output logic                      m1_gnt_o,
  input  logic [BUS_ADDR_WIDTH-1:0] m1_addr_i,
  input  logic                      m1_we_i,
  input  logic [DATA_WIDTH/8-1:0]   m1_be_i,
  input  logic [DATA_WIDTH-1:0]     m1_wdata_i,
  output logic                      m1_rvalid_o,
  output logic [DATA_WIDTH-1:0]     m1_rdata_o,
  output logic                      m1_err_o,
  output logic                      ram_en_o,
  output logic                      ram_we_o,
  output logic [DATA_WIDTH/8-1:0]   ram_be_o,
  output logic [ADDR_WIDTH-1:0]     ram_addr_o,
  output logic [DATA_WIDTH-1:0]     ram_wdata_o,
  input  logic [DATA_WIDTH-1:0]     ram_rdata_i,
  input  logic                      perf_clr_i,
  output logic [3:0][31:0]          perf_cnt_o
);

  localparam logic [BUS_ADDR_WIDTH-1:0] RAM_LIMIT = BUS_ADDR_WIDTH'(RAM_SIZE);

  logic [NUM_MASTERS-1:0] req_live;
  logic [NUM_MASTERS-1:0] gnt;
  master_id_t             rr_q;
  master_id_t             sel;
  logic                   any_gnt;
  logic                   in_range;
  ram_req_t               req0, req1, req_sel;
  ram_resp_t              resp_q;
  logic                   rvalid0, rvalid1, rd_ok;

  // Requests seen while reset is high are never granted.
  assign req_live = {m1_req_i, m0_req_i} & {NUM_MASTERS{~rst_i}};

  ram_rr_arbiter u_arb (
    .clk   (clk),
    .rst_i (rst_i),
    .req   (req_live),
    .taken (any_gnt),
    .gnt   (gnt),
    .rr_q  (rr_q)
  );

  assign any_gnt = |gnt;
  // Granted master index: the sole requester, or the pointer on a tie.
  assign sel     = (req_live == 2'b11) ? rr_q : req_live[1];

  assign req0    = '{we: m0_we_i, be: m0_be_i, addr: m0_addr_i, wdata: m0_wdata_i};
  assign req1    = '{we: m1_we_i, be: m1_be_i, addr: m1_addr_i, wdata: m1_wdata_i};
  assign req_sel = sel ? req1 : req0;

  assign in_range = req_sel.addr < RAM_LIMIT;

  assign m0_gnt_o    = gnt[0];
  assign m1_gnt_o    = gnt[1];
  assign ram_en_o    = any_gnt & in_range;
  assign ram_we_o    = any_gnt & req_sel.we;
  assign ram_be_o    = any_gnt ? req_sel.be : '0;
  assign ram_addr_o  = any_gnt ? req_sel.addr[ADDR_WIDTH-1:0] : '0;
  assign ram_wdata_o = any_gnt ? req_sel.wdata : '0;

  // Response tag follows the grant by exactly one cycle.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      resp_q <= '0;
    end else begin
      resp_q <= '{vld: any_gnt, id: sel, we: req_sel.we, err: ~in_range};
    end
  end

  // Gated by reset so a response pending at reset never reaches a master.
  assign rvalid0 = resp_q.vld & (resp_q.id == 1'b0) & ~rst_i;
  assign rvalid1 = resp_q.vld & (resp_q.id == 1'b1) & ~rst_i;
  assign rd_ok   = ~resp_q.we & ~resp_q.err;

  assign m0_rvalid_o = rvalid0;
  assign m1_rvalid_o = rvalid1;
  assign m0_err_o    = rvalid0 & resp_q.err;
  assign m1_err_o    = rvalid1 & resp_q.err;
  assign m0_rdata_o  = (rvalid0 & rd_ok) ? ram_rdata_i : '0;
  assign m1_rdata_o  = (rvalid1 & rd_ok) ? ram_rdata_i : '0;

`ifdef RAM_ARB_PERF_EN
  logic [3:0][31:0] perf_q;
  logic [3:0]       perf_inc;

  assign perf_inc = {req_live[1] & ~gnt[1], gnt[1], req_live[0] & ~gnt[0], gnt[0]};

  // Clear wins over any increment in the same cycle.
  always_ff @(posedge clk) begin
    if (rst_i || perf_clr_i) begin
      perf_q <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (perf_inc[i]) perf_q[i] <= sat_inc(perf_q[i]);
      end
    end
  end

  assign perf_cnt_o = perf_q;
`else
  logic unused_perf_clr;
  assign unused_perf_clr = perf_clr_i;
  assign perf_cnt_o      = '0;
`endif

endmodule
